// File: rtl/mem_port_arbiter.sv
// Purpose     : shares one single-port synchronous memory between the CPU datapath and a loader/debug port.
// Latency     : 3 cycles from the request-sampling edge to the done pulse; one access per 4 cycles.
// Backpressure: requests are only sampled in IDLE; the loser keeps req high and is served next.
//
// Ports:
//   clk, rst                               rising-edge clock, synchronous active-high reset
//   cpu_req/we/addr/wdata -> cpu_gnt/done/rdata   CPU requester
//   ldr_req/we/addr/wdata -> ldr_gnt/done/rdata   loader/debug requester
//   mem_en/we/addr/wdata (registered), mem_rdata  memory macro (read data valid the cycle after mem_en)
//   busy                                   transaction in flight
//
// Build option: MEM_ARB_LDR_PRIO_EN gives the loader fixed priority on ties;
// left undefined, ties are resolved round-robin.
module mem_port_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_done,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_gnt,
    output logic          ldr_done,
    output logic [DW-1:0] ldr_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t state;
    logic   owner;      // 1 = loader owns the current transaction
    logic   pick_ldr;   // arbitration result for the IDLE cycle

`ifdef MEM_ARB_LDR_PRIO_EN
    always_comb begin
        pick_ldr = ldr_req;
    end
`else
    logic last_owner;   // 1 = loader was granted last

    // On a tie, serve whoever was not granted last.
    always_comb begin
        pick_ldr = ldr_req & (~cpu_req | ~last_owner);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            owner     <= 1'b0;
`ifndef MEM_ARB_LDR_PRIO_EN
            last_owner <= 1'b1;     // CPU wins the first tie
`endif
            cpu_gnt   <= 1'b0;
            cpu_done  <= 1'b0;
            cpu_rdata <= '0;
            ldr_gnt   <= 1'b0;
            ldr_done  <= 1'b0;
            ldr_rdata <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_req || ldr_req) begin
                        // Latch the winner's fields; they hold for the whole
                        // transaction regardless of later input changes.
                        owner     <= pick_ldr;
`ifndef MEM_ARB_LDR_PRIO_EN
                        last_owner <= pick_ldr;
`endif
                        mem_en    <= 1'b1;
                        mem_we    <= pick_ldr ? ldr_we    : cpu_we;
                        mem_addr  <= pick_ldr ? ldr_addr  : cpu_addr;
                        mem_wdata <= pick_ldr ? ldr_wdata : cpu_wdata;
                        cpu_gnt   <= ~pick_ldr;
                        ldr_gnt   <= pick_ldr;
                        busy      <= 1'b1;
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    mem_en <= 1'b0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    // Memory read data is valid this cycle; writes leave rdata alone.
                    if (!mem_we) begin
                        if (owner) begin
                            ldr_rdata <= mem_rdata;
                        end else begin
                            cpu_rdata <= mem_rdata;
                        end
                    end
                    cpu_done <= ~owner;
                    ldr_done <= owner;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    cpu_done <= 1'b0;
                    ldr_done <= 1'b0;
                    cpu_gnt  <= 1'b0;
                    ldr_gnt  <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the Simple CPU's single-port synchronous data/instruction memory. It shares the port between the CPU datapath and a loader/debug port that fills memory or inspects it. Each access runs as a fixed three-state transaction: request, grant, completion pulse. The block sits between the CU-driven datapath memory signals, the loader, and the memory macro.

## Interface
Parameters:
- `AW`, 8, memory address width.
- `DW`, 16, memory data width.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  CPU access request; the CPU holds it and the fields below stable until `cpu_done`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  AW  CPU address.
- `cpu_wdata`  in  DW  CPU write data.
- `cpu_gnt`  out  1  CPU owns the port (ACCESS, WAIT, DONE).
- `cpu_done`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  DW  read data register; valid while `cpu_done` = 1 and held until the next CPU read completes.
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_gnt`, `ldr_done`, `ldr_rdata`: loader port, identical semantics.
- `mem_en`  out  1  memory enable; registered.
- `mem_we`  out  1  memory write enable; registered.
- `mem_addr`  out  AW  registered.
- `mem_wdata`  out  DW  registered.
- `mem_rdata`  in  DW  memory read data, valid the cycle after `mem_en` (synchronous read).
- `busy`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE: if any request is high, select the owner, latch its `we`/`addr`/`wdata` into `mem_*`, set `mem_en` = 1, go to ACCESS. Otherwise stay in IDLE.
- ACCESS: `mem_en` = 1 for exactly this cycle; next state is WAIT.
- WAIT: `mem_en` = 0. On a read, capture `mem_rdata` into the owner's `rdata` register. On a write, leave `rdata` unchanged. Next state is DONE.
- DONE: pulse the owner's `done`. Next state is IDLE.
- Arbitration is round-robin. A `last_owner` flag updates at grant.
  - Simultaneous requests in IDLE: grant the requester that is not `last_owner`.
  - A single request is granted immediately.
- A request still high in the IDLE cycle after `done` is a new transaction. A requester must drop `req` at the edge where it samples `done` if it wants only one access.
- Request inputs are ignored outside IDLE. The latched fields hold the transaction, so the owner may change its inputs after the grant without effect.
- The owner's `gnt` is high in ACCESS, WAIT and DONE. The non-owner's `gnt` and `done` stay 0.
- Reset values: state IDLE, `last_owner` = LDR (so the CPU wins the first tie), all outputs 0, including `cpu_rdata` and `ldr_rdata`.
- Reset mid-transaction: return to IDLE on the next edge; no `done` is issued.
  - A write whose `mem_en` was already sampled by memory may have committed. Requesters must reissue after reset.

## Timing
- Request sampled high at the end of IDLE cycle t:
  - t+1: ACCESS, `mem_en` = 1.
  - t+2: WAIT; `mem_rdata` is valid and captured at the end of t+2.
  - t+3: DONE, `done` = 1, `rdata` valid.
  - t+4: IDLE.
- Per-access latency is 3 cycles from the sampling edge to `done`. Port throughput is one access per 4 cycles.
- Back-to-back requests under contention alternate owners: CPU, LDR, CPU, ...
- No combinational path from any `req` to `mem_*`.

## Configuration
- `MEM_ARB_LDR_PRIO_EN` defined: the loader has fixed priority. Simultaneous requests always grant LDR, and `last_owner` is unused. A continuously requesting loader starves the CPU; this is intended for boot/debug loading while the CU is held.
- Not defined: round-robin as described above.

## Test plan
- Reset, then CPU write addr 0x10 data 0x1234 followed by a CPU read of 0x10: `mem_en` is high exactly one cycle per access; `cpu_done` occurs 3 cycles after each sampling edge; `cpu_rdata` = 0x1234; all `ldr_*` outputs stay 0.
- Both requesters assert in the same cycle after reset and hold `req` for two transactions each: grant order CPU, LDR, CPU, LDR; each `done` spaced 4 cycles.
- With `MEM_ARB_LDR_PRIO_EN` defined, the same stimulus: grant order LDR, LDR, CPU, CPU.
- LDR reads 0x20 (preloaded 0xBEEF), then CPU writes 0x20 = 0x0001: `ldr_rdata` = 0xBEEF and stays held through the CPU write; `cpu_rdata` is unchanged.
- CPU changes `cpu_addr` from 0x05 to 0x06 in the ACCESS cycle: `mem_addr` stays 0x05 for the whole transaction.
- Assert `rst` in the WAIT cycle of a CPU read: next cycle IDLE with all outputs 0; no `cpu_done`; a fresh request afterwards completes with normal latency.
